// File: rtl/ram_pkg.sv
// ram_pkg: shared types and defaults for the ram_resp_sync responder.
//   state_e        : responder FSM states (zero-fill sweep / normal service)
//   *_DEF          : default geometry and read latency
//   RD_LAT_MIN/MAX : supported read latencies, checked through rd_lat_ok()
package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 1024;
  localparam int RD_LAT_DEF = 1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_resp_sync_if.sv
// ram_resp_sync_if: request/response bundle between a RAM initiator and the
// ram_resp_sync responder.
//   select/write/address/data_in   : request, driven by the initiator
//   ready                          : responder accepts select this cycle
//   data_out/rvalid                : read data and its one-cycle strobe
//   wr_ack                         : one-cycle write confirmation
//   err                            : completing request was out of range
interface ram_resp_sync_if
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              select;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              rvalid;
  logic              wr_ack;
  logic              err;

  modport master (
    output select, write, address, data_in,
    input  ready, data_out, rvalid, wr_ack, err
  );

  modport slave (
    input  select, write, address, data_in,
    output ready, data_out, rvalid, wr_ack, err
  );

endinterface

// File: rtl/ram_array_1rw.sv
// ram_array_1rw: DEPTH x DATA_W storage with one shared address, a write
// enable and a registered read port.
//   clk, rst  : clock and synchronous active-high reset (read register only)
//   we_i      : write wdata_i to mem[addr_i]
//   re_i      : register mem[addr_i] into rdata_o
//   rclr_i    : register zero into rdata_o (out-of-range read)
//   addr_i    : word address, must be < DEPTH when we_i or re_i is set
//   wdata_i   : write data
//   rdata_o   : registered read data, holds between reads
module ram_array_1rw #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rclr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are not reset; the responder zero-fills them after every reset.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else if (rclr_i) begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_resp_sync.sv
// ram_resp_sync: memory-side responder for the select/write/address/data
// RAM interface. Zero-fills the array after reset, then accepts one request
// per cycle with no back-pressure, returns read data after RD_LAT cycles and
// flags out-of-range addresses.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ram_resp_sync_if slave modport (request in, response out)
module ram_resp_sync
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input logic           clk,
  input logic           rst,
  ram_resp_sync_if.slave bus
);

  // Any latency other than the legal maximum uses the single-stage path.
  localparam bit TWO_STAGE = rd_lat_ok(RD_LAT) && (RD_LAT == RD_LAT_MAX);
  // One extra bit so DEPTH == 2**ADDR_W is representable without wrap.
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
  logic              ready_q;
  logic              wr_ack_q, wr_err_q;
  logic              rv1_q, rerr1_q;

  logic              acc, acc_wr, acc_rd, in_range;
  logic              arr_we, arr_re, arr_rclr;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_err;

  assign acc      = bus.select & ready_q;
  assign acc_wr   = acc & bus.write;
  assign acc_rd   = acc & ~bus.write;
  assign in_range = {1'b0, bus.address} < DEPTH_W;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: leave INIT on the edge that writes the last word.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + CNT_ONE;
      if (init_cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
      end
    end
  end

  // Outputs to the array: the fill sweep owns the port during INIT.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_rclr  = 1'b0;
    arr_addr  = bus.address;
    arr_wdata = bus.data_in;
    if (state_q == ST_INIT) begin
      arr_we    = 1'b1;
      arr_addr  = init_cnt_q[ADDR_W-1:0];
      arr_wdata = '0;
    end else begin
      arr_we   = acc_wr & in_range;
      arr_re   = acc_rd & in_range;
      arr_rclr = acc_rd & ~in_range;
    end
  end

  // ready follows the state one cycle later, so it rises DEPTH edges after
  // reset release and the sweep is complete before any request is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rv1_q    <= 1'b0;
      rerr1_q  <= 1'b0;
    end else begin
      ready_q  <= (state_q == ST_RUN);
      wr_ack_q <= acc_wr;
      wr_err_q <= acc_wr & ~in_range;
      rv1_q    <= acc_rd;
      rerr1_q  <= acc_rd & ~in_range;
    end
  end

  ram_array_1rw #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .rclr_i  (arr_rclr),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  if (TWO_STAGE) begin : g_rd_stage2
    logic [DATA_W-1:0] rdata2_q;
    logic              rv2_q, rerr2_q;

    // Data only advances with a valid read so data_out holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata2_q <= '0;
        rv2_q    <= 1'b0;
        rerr2_q  <= 1'b0;
      end else begin
        rv2_q   <= rv1_q;
        rerr2_q <= rerr1_q;
        if (rv1_q) begin
          rdata2_q <= arr_rdata;
        end
      end
    end

    assign rd_data  = rdata2_q;
    assign rd_valid = rv2_q;
    assign rd_err   = rerr2_q;
  end else begin : g_rd_stage1
    assign rd_data  = arr_rdata;
    assign rd_valid = rv1_q;
    assign rd_err   = rerr1_q;
  end

  assign bus.ready    = ready_q;
  assign bus.data_out = rd_data;
  assign bus.rvalid   = rd_valid;
  assign bus.wr_ack   = wr_ack_q;
  // With two read stages a read and a later write can complete together.
  assign bus.err      = rd_err | wr_err_q;

endmodule

// File: tb/tb_ram_resp_sync.sv
// Scoreboard bench for ram_resp_sync. Two responders share one request
// stream: A is the default geometry (DEPTH 1024, RD_LAT 1), B has
// DEPTH 1000 and RD_LAT 2.
module tb_ram_resp_sync;

  localparam int DEP [2] = '{1024, 1000};
  localparam int LAT [2] = '{1, 2};

  typedef struct {
    int         n;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel, wr;
  logic [9:0] addr;
  logic [7:0] din;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic       rdy [2];
  logic       rv  [2];
  logic       wa  [2];
  logic       er  [2];
  logic [7:0] dout[2];

  exp_t       rq[2][$];
  exp_t       wq[2][$];
  logic [7:0] mem_m[2][1024];
  exp_t       e_m, e_r, e_w;
  logic       oor_m, exp_err;
  int         first[2];

  always #5 clk = ~clk;

  ram_resp_sync_if #(.ADDR_W(10), .DATA_W(8)) bus_a ();
  ram_resp_sync_if #(.ADDR_W(10), .DATA_W(8)) bus_b ();

  assign bus_a.select  = sel;
  assign bus_a.write   = wr;
  assign bus_a.address = addr;
  assign bus_a.data_in = din;
  assign bus_b.select  = sel;
  assign bus_b.write   = wr;
  assign bus_b.address = addr;
  assign bus_b.data_in = din;

  assign rdy[0] = bus_a.ready;  assign rdy[1] = bus_b.ready;
  assign rv[0]  = bus_a.rvalid; assign rv[1]  = bus_b.rvalid;
  assign wa[0]  = bus_a.wr_ack; assign wa[1]  = bus_b.wr_ack;
  assign er[0]  = bus_a.err;    assign er[1]  = bus_b.err;
  assign dout[0] = bus_a.data_out;
  assign dout[1] = bus_b.data_out;

  ram_resp_sync #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .RD_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  ram_resp_sync #(.ADDR_W(10), .DATA_W(8), .DEPTH(1000), .RD_LAT(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: on each accepted request, update the model memory and
  // push the response the responder owes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rq[i].delete();
        wq[i].delete();
        for (int a = 0; a < 1024; a++) mem_m[i][a] <= 8'h00;
      end else if (sel && rdy[i]) begin
        oor_m  = (int'(addr) >= DEP[i]);
        e_m.n   = cyc;
        e_m.err = oor_m;
        if (wr) begin
          e_m.data = 8'h00;
          wq[i].push_back(e_m);
          if (!oor_m) mem_m[i][addr] <= din;
        end else begin
          e_m.data = oor_m ? 8'h00 : mem_m[i][addr];
          rq[i].push_back(e_m);
        end
      end
    end
  end

  // Response checker, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_err = 1'b0;
      if (rv[i]) begin
        if (rq[i].size() == 0) chk($sformatf("rvalid_unexpected%0d", i), rv[i], 0);
        else begin
          e_r = rq[i].pop_front();
          chk($sformatf("rdata%0d", i), dout[i], e_r.data);
          chk($sformatf("rd_latency%0d", i), cyc - e_r.n, LAT[i]);
          exp_err |= e_r.err;
        end
      end else if (rq[i].size() != 0 && (cyc - rq[i][0].n) >= LAT[i]) begin
        chk($sformatf("rvalid_missing%0d", i), rv[i], 1);
        void'(rq[i].pop_front());
      end
      if (wa[i]) begin
        if (wq[i].size() == 0) chk($sformatf("wr_ack_unexpected%0d", i), wa[i], 0);
        else begin
          e_w = wq[i].pop_front();
          chk($sformatf("wr_latency%0d", i), cyc - e_w.n, 1);
          exp_err |= e_w.err;
        end
      end else if (wq[i].size() != 0 && (cyc - wq[i][0].n) >= 1) begin
        chk($sformatf("wr_ack_missing%0d", i), wa[i], 1);
        void'(wq[i].pop_front());
      end
      chk($sformatf("err%0d", i), er[i], exp_err);
    end
  end

  task automatic req(input bit w, input int a, input int d);
    @(posedge clk); #1;
    sel  = 1'b1;
    wr   = w;
    addr = a[9:0];
    din  = d[7:0];
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    sel = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called with rst just released: counts cycles from the first edge with
  // rst low until each ready rises, bounded.
  task automatic measure_ready(input string tag);
    first[0] = 0;
    first[1] = 0;
    @(posedge clk);
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (rdy[i] && first[i] == 0) first[i] = c;
    end
    chk({tag, "_ready_cycle0"}, first[0], 1025);
    chk({tag, "_ready_cycle1"}, first[1], 1001);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; wr = 1'b0; addr = '0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), rdy[i], 0);
      chk($sformatf("rst_rvalid%0d", i), rv[i], 0);
      chk($sformatf("rst_data%0d", i), dout[i], 0);
      chk($sformatf("rst_wr_ack%0d", i), wa[i], 0);
      chk($sformatf("rst_err%0d", i), er[i], 0);
    end

    // Release reset with a read of address 0 held throughout INIT.
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b1; wr = 1'b0; addr = 10'd0;
    measure_ready("init");

    req(0, 0, 0); req(0, 511, 0); req(0, 1023, 0);

    for (int k = 1; k <= 16; k++) req(1, k, k + 2);
    for (int k = 1; k <= 16; k++) req(0, k, 0);

    // Out-of-range on B only; 986 and 10 must stay intact.
    req(1, 986, 8'h33);
    req(1, 1010, 8'hAA);
    req(0, 1010, 0);
    req(0, 986, 0);
    req(0, 10, 0);
    req(0, 1005, 0);

    // Read-after-write on the next edge.
    req(1, 7, 8'h5C);
    req(0, 7, 0);
    idle(3);

    // Reset while a read is in flight.
    req(0, 3, 0);
    @(posedge clk); #1;
    sel = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_ready0", rdy[0], 0);
    chk("midrst_ready1", rdy[1], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    measure_ready("restart");
    req(0, 3, 0);

    // Known fill, then seeded random reads.
    for (int a = 0; a < 1024; a++) req(1, a, (a * 37 + 5) & 8'hFF);
    void'($urandom(20));
    for (int r = 0; r < 20; r++) req(0, int'($urandom_range(1023, 0)), 0);

    idle(6);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("drained%0d", i), rq[i].size() + wq[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
